// File: rtl/mandelbrot_iter.sv
// One Mandelbrot iteration z <- z^2 + c as a fixed 3-cycle pipeline with video syncs carried alongside.
// Define MANDELBROT_SAT_EN to saturate the new z; otherwise it wraps modulo 2^W.
module mandelbrot_iter #(
    parameter int W        = 16,
    parameter int FRAC     = 12,
    parameter int CNT_W    = 8,
    parameter int MAX_ITER = 255,
    parameter int ESC_R2   = 4 << FRAC
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic                 i_de,
    input  logic                 i_vs,
    input  logic                 i_hs,
    input  logic signed [W-1:0]  i_x,
    input  logic signed [W-1:0]  i_y,
    input  logic signed [W-1:0]  i_cx,
    input  logic signed [W-1:0]  i_cy,
    input  logic [CNT_W-1:0]     i_cnt,
    input  logic                 i_done,
    output logic                 o_de,
    output logic                 o_vs,
    output logic                 o_hs,
    output logic signed [W-1:0]  o_x,
    output logic signed [W-1:0]  o_y,
    output logic signed [W-1:0]  o_cx,
    output logic signed [W-1:0]  o_cy,
    output logic [CNT_W-1:0]     o_cnt,
    output logic                 o_done
);

    localparam int PW = 2 * W;
    localparam int EW = W + 2;
    localparam int CW = W + 3;

    localparam logic signed [EW-1:0] ESC_V = EW'(ESC_R2);
    localparam logic [CNT_W:0]       MAX_V = (CNT_W + 1)'(MAX_ITER);

    // ------------------------------------------------------------------
    // Stage 0: full-width products and the carried pixel fields
    // ------------------------------------------------------------------
    logic signed [PW-1:0] x_ext;
    logic signed [PW-1:0] y_ext;

    assign x_ext = {{W{i_x[W-1]}}, i_x};
    assign y_ext = {{W{i_y[W-1]}}, i_y};

    logic signed [PW-1:0] s0_xx_q, s0_yy_q, s0_xy_q;
    logic signed [W-1:0]  s0_x_q, s0_y_q, s0_cx_q, s0_cy_q;
    logic [CNT_W-1:0]     s0_cnt_q;
    logic                 s0_done_q;
    logic [2:0]           s0_sync_q;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            s0_xx_q   <= '0;
            s0_yy_q   <= '0;
            s0_xy_q   <= '0;
            s0_x_q    <= '0;
            s0_y_q    <= '0;
            s0_cx_q   <= '0;
            s0_cy_q   <= '0;
            s0_cnt_q  <= '0;
            s0_done_q <= 1'b0;
            s0_sync_q <= '0;
        end else begin
            s0_xx_q   <= x_ext * x_ext;
            s0_yy_q   <= y_ext * y_ext;
            s0_xy_q   <= x_ext * y_ext;
            s0_x_q    <= i_x;
            s0_y_q    <= i_y;
            s0_cx_q   <= i_cx;
            s0_cy_q   <= i_cy;
            s0_cnt_q  <= i_cnt;
            s0_done_q <= i_done;
            s0_sync_q <= {i_de, i_vs, i_hs};
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: rescale, overflow flag, sums at W+2 bits
    // ------------------------------------------------------------------
    function automatic logic fits_w(input logic signed [PW-1:0] v);
        // Representable in W signed bits when the top bits are all sign copies.
        return (&v[PW-1:W-1]) | ~(|v[PW-1:W-1]);
    endfunction

    logic signed [PW-1:0] xx_sh, yy_sh, xy_sh;
    logic signed [W-1:0]  xx_t, yy_t, xy_t;
    logic signed [EW-1:0] diff_d, twoxy_d, mag2_d;
    logic                 ovf_d;

    always_comb begin
        xx_sh   = s0_xx_q >>> FRAC;
        yy_sh   = s0_yy_q >>> FRAC;
        xy_sh   = s0_xy_q >>> FRAC;
        ovf_d   = ~(fits_w(xx_sh) & fits_w(yy_sh) & fits_w(xy_sh));
        xx_t    = xx_sh[W-1:0];
        yy_t    = yy_sh[W-1:0];
        xy_t    = xy_sh[W-1:0];
        diff_d  = {{2{xx_t[W-1]}}, xx_t} - {{2{yy_t[W-1]}}, yy_t};
        twoxy_d = {xy_t[W-1], xy_t, 1'b0};
        mag2_d  = {{2{xx_t[W-1]}}, xx_t} + {{2{yy_t[W-1]}}, yy_t};
    end

    logic signed [EW-1:0] s1_diff_q, s1_twoxy_q, s1_mag2_q;
    logic                 s1_ovf_q;
    logic signed [W-1:0]  s1_x_q, s1_y_q, s1_cx_q, s1_cy_q;
    logic [CNT_W-1:0]     s1_cnt_q;
    logic                 s1_done_q;
    logic [2:0]           s1_sync_q;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            s1_diff_q  <= '0;
            s1_twoxy_q <= '0;
            s1_mag2_q  <= '0;
            s1_ovf_q   <= 1'b0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            s1_cx_q    <= '0;
            s1_cy_q    <= '0;
            s1_cnt_q   <= '0;
            s1_done_q  <= 1'b0;
            s1_sync_q  <= '0;
        end else begin
            s1_diff_q  <= diff_d;
            s1_twoxy_q <= twoxy_d;
            s1_mag2_q  <= mag2_d;
            s1_ovf_q   <= ovf_d;
            s1_x_q     <= s0_x_q;
            s1_y_q     <= s0_y_q;
            s1_cx_q    <= s0_cx_q;
            s1_cy_q    <= s0_cy_q;
            s1_cnt_q   <= s0_cnt_q;
            s1_done_q  <= s0_done_q;
            s1_sync_q  <= s0_sync_q;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: candidate z, escape test and output selection
    // ------------------------------------------------------------------
`ifdef MANDELBROT_SAT_EN
    localparam logic signed [CW-1:0] ZMAX = {4'b0000, {(W-1){1'b1}}};
    localparam logic signed [CW-1:0] ZMIN = {4'b1111, {(W-1){1'b0}}};

    function automatic logic signed [W-1:0] reduce_z(input logic signed [CW-1:0] v);
        if (v > ZMAX) begin
            return ZMAX[W-1:0];
        end else if (v < ZMIN) begin
            return ZMIN[W-1:0];
        end
        return v[W-1:0];
    endfunction
`else
    function automatic logic signed [W-1:0] reduce_z(input logic signed [CW-1:0] v);
        return v[W-1:0];
    endfunction
`endif

    logic signed [CW-1:0] nx_full, ny_full;
    logic                 escape;
    logic                 at_limit;
    logic [CNT_W:0]       cnt_inc;
    logic signed [W-1:0]  x_d, y_d;
    logic [CNT_W-1:0]     cnt_d;
    logic                 done_d;

    always_comb begin
        nx_full  = {s1_diff_q[EW-1], s1_diff_q} + {{3{s1_cx_q[W-1]}}, s1_cx_q};
        ny_full  = {s1_twoxy_q[EW-1], s1_twoxy_q} + {{3{s1_cy_q[W-1]}}, s1_cy_q};
        escape   = s1_ovf_q | (s1_mag2_q > ESC_V);
        at_limit = ({1'b0, s1_cnt_q} >= MAX_V);
        cnt_inc  = {1'b0, s1_cnt_q} + (CNT_W + 1)'(1);
        // Finished, limited or escaped pixels keep z and count frozen.
        x_d      = s1_x_q;
        y_d      = s1_y_q;
        cnt_d    = s1_cnt_q;
        done_d   = 1'b1;
        if (!s1_done_q && !at_limit && !escape) begin
            x_d    = reduce_z(nx_full);
            y_d    = reduce_z(ny_full);
            cnt_d  = cnt_inc[CNT_W-1:0];
            done_d = (cnt_inc == MAX_V);
        end
    end

    logic signed [W-1:0] out_x_q, out_y_q, out_cx_q, out_cy_q;
    logic [CNT_W-1:0]    out_cnt_q;
    logic                out_done_q;
    logic [2:0]          out_sync_q;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            out_x_q    <= '0;
            out_y_q    <= '0;
            out_cx_q   <= '0;
            out_cy_q   <= '0;
            out_cnt_q  <= '0;
            out_done_q <= 1'b0;
            out_sync_q <= '0;
        end else begin
            out_x_q    <= x_d;
            out_y_q    <= y_d;
            out_cx_q   <= s1_cx_q;
            out_cy_q   <= s1_cy_q;
            out_cnt_q  <= cnt_d;
            out_done_q <= done_d;
            out_sync_q <= s1_sync_q;
        end
    end

    assign o_de   = out_sync_q[2];
    assign o_vs   = out_sync_q[1];
    assign o_hs   = out_sync_q[0];
    assign o_x    = out_x_q;
    assign o_y    = out_y_q;
    assign o_cx   = out_cx_q;
    assign o_cy   = out_cy_q;
    assign o_cnt  = out_cnt_q;
    assign o_done = out_done_q;

endmodule

// File: tb/tb_mandelbrot_iter.sv
// Bench for mandelbrot_iter: arithmetic reference model checked every cycle plus hand-computed vectors.
module tb_mandelbrot_iter;

    localparam int FRAC     = 12;
    localparam int MAX_ITER = 255;

    logic        clk = 1'b0;
    logic        rstn;
    logic        de, vs, hs, done;
    logic [15:0] x, y, cx, cy;
    logic [7:0]  cnt;
    logic        o_de, o_vs, o_hs, o_done;
    logic [15:0] o_x, o_y, o_cx, o_cy;
    logic [7:0]  o_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mandelbrot_iter dut (
        .i_clk (clk),  .i_rstn(rstn),
        .i_de  (de),   .i_vs  (vs),   .i_hs (hs),
        .i_x   (x),    .i_y   (y),    .i_cx (cx),   .i_cy(cy),
        .i_cnt (cnt),  .i_done(done),
        .o_de  (o_de), .o_vs  (o_vs), .o_hs (o_hs),
        .o_x   (o_x),  .o_y   (o_y),  .o_cx (o_cx), .o_cy(o_cy),
        .o_cnt (o_cnt), .o_done(o_done)
    );

    typedef struct packed {
        logic        de, vs, hs;
        logic [15:0] x, y, cx, cy;
        logic [7:0]  cnt;
        logic        done;
    } pix_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] reduce(input longint v);
`ifdef MANDELBROT_SAT_EN
        if (v > 32767) return 16'h7FFF;
        if (v < -32768) return 16'h8000;
`endif
        return v[15:0];
    endfunction

    function automatic bit in_range(input longint v);
        return (v >= -32768) && (v <= 32767);
    endfunction

    // Reference: real-valued Q4.12 iteration step in wide integers.
    function automatic pix_t model(input pix_t in);
        pix_t   r;
        longint xl, yl, cxl, cyl, xx, yy, xy, mag2;
        bit     ovf, esc;
        xl   = longint'($signed(in.x));
        yl   = longint'($signed(in.y));
        cxl  = longint'($signed(in.cx));
        cyl  = longint'($signed(in.cy));
        xx   = (xl * xl) >>> FRAC;
        yy   = (yl * yl) >>> FRAC;
        xy   = (xl * yl) >>> FRAC;
        ovf  = !(in_range(xx) && in_range(yy) && in_range(xy));
        mag2 = xx + yy;
        esc  = ovf || (mag2 > (longint'(4) << FRAC));
        r      = in;
        r.done = 1'b1;
        if (!in.done && (int'(in.cnt) < MAX_ITER) && !esc) begin
            r.x    = reduce(xx - yy + cxl);
            r.y    = reduce(2 * xy + cyl);
            r.cnt  = in.cnt + 8'd1;
            r.done = (int'(in.cnt) + 1 == MAX_ITER);
        end
        return r;
    endfunction

    pix_t in_s, act_s;
    pix_t m_q [3];
    logic [2:0] mv_q;

    assign in_s  = {de, vs, hs, x, y, cx, cy, cnt, done};
    assign act_s = {o_de, o_vs, o_hs, o_x, o_y, o_cx, o_cy, o_cnt, o_done};

    // Three-cycle latency line of expected results; reset discards everything in flight.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mv_q <= 3'b000;
        end else begin
            m_q[0] <= model(in_s);
            m_q[1] <= m_q[0];
            m_q[2] <= m_q[1];
            mv_q   <= {mv_q[1:0], 1'b1};
        end
    end

    task automatic chk_pix(input string tag, input pix_t a, input pix_t e);
        chk({tag, ".de"},   32'(a.de),   32'(e.de));
        chk({tag, ".vs"},   32'(a.vs),   32'(e.vs));
        chk({tag, ".hs"},   32'(a.hs),   32'(e.hs));
        chk({tag, ".x"},    32'(a.x),    32'(e.x));
        chk({tag, ".y"},    32'(a.y),    32'(e.y));
        chk({tag, ".cx"},   32'(a.cx),   32'(e.cx));
        chk({tag, ".cy"},   32'(a.cy),   32'(e.cy));
        chk({tag, ".cnt"},  32'(a.cnt),  32'(e.cnt));
        chk({tag, ".done"}, 32'(a.done), 32'(e.done));
    endtask

    always @(negedge clk) begin
        if (!rstn) begin
            chk_pix("reset", act_s, '0);
        end else if (mv_q[2]) begin
            chk_pix("model", act_s, m_q[2]);
        end else begin
            chk("flush.de", 32'(o_de), 32'd0);
            chk("flush.vs", 32'(o_vs), 32'd0);
            chk("flush.hs", 32'(o_hs), 32'd0);
        end
    end

    task automatic vec(input string name,
                       input logic [15:0] vx, vy, vcx, vcy, input logic [7:0] vcnt, input logic vdone,
                       input logic [15:0] ex, ey, input logic [7:0] ecnt, input logic edone);
        @(posedge clk);
        #2;
        de = 1'b1; vs = 1'b0; hs = 1'b1;
        x = vx; y = vy; cx = vcx; cy = vcy; cnt = vcnt; done = vdone;
        repeat (3) @(posedge clk);
        #3;
        chk({name, ".x"},    32'(o_x),    32'(ex));
        chk({name, ".y"},    32'(o_y),    32'(ey));
        chk({name, ".cnt"},  32'(o_cnt),  32'(ecnt));
        chk({name, ".done"}, 32'(o_done), 32'(edone));
        $display("vec %-8s z=(%h,%h) c=(%h,%h) cnt=%0d done=%0b -> z=(%h,%h) cnt=%0d done=%0b",
                 name, vx, vy, vcx, vcy, vcnt, vdone, o_x, o_y, o_cnt, o_done);
    endtask

`ifdef MANDELBROT_SAT_EN
    localparam logic [15:0] EXP_BIG_X = 16'h7FFF;
`else
    localparam logic [15:0] EXP_BIG_X = 16'hB000;
`endif

    initial begin
        rstn = 1'b0;
        de = 1'b0; vs = 1'b0; hs = 1'b0; done = 1'b0;
        x = '0; y = '0; cx = '0; cy = '0; cnt = '0;
        repeat (3) @(posedge clk);
        #2;
        rstn = 1'b1;

        vec("basic",  16'h0000, 16'h0000, 16'h0800, 16'h0000, 8'd0,   1'b0, 16'h0800, 16'h0000, 8'd1,   1'b0);
        vec("esc4p5", 16'h1800, 16'h1800, 16'h0000, 16'h0000, 8'd7,   1'b0, 16'h1800, 16'h1800, 8'd7,   1'b1);
        vec("edge4x", 16'h2000, 16'h0000, 16'h0000, 16'h0000, 8'd7,   1'b0, 16'h4000, 16'h0000, 8'd8,   1'b0);
        vec("edge4y", 16'h0000, 16'h2000, 16'h0100, 16'h0000, 8'd10,  1'b0, 16'hC100, 16'h0000, 8'd11,  1'b0);
        vec("indone", 16'h1234, 16'h0567, 16'h0100, 16'h0200, 8'd42,  1'b1, 16'h1234, 16'h0567, 8'd42,  1'b1);
        vec("ovf",    16'h7000, 16'h7000, 16'h0000, 16'h0000, 8'd3,   1'b0, 16'h7000, 16'h7000, 8'd3,   1'b1);
        vec("last",   16'h0000, 16'h0000, 16'h0000, 16'h0000, 8'd254, 1'b0, 16'h0000, 16'h0000, 8'd255, 1'b1);
        vec("atmax",  16'h0000, 16'h0000, 16'h0000, 16'h0000, 8'd255, 1'b0, 16'h0000, 16'h0000, 8'd255, 1'b1);
        vec("bigx",   16'h2000, 16'h0000, 16'h7000, 16'h0000, 8'd5,   1'b0, EXP_BIG_X, 16'h0000, 8'd6,  1'b0);
        vec("neg",    16'hF000, 16'h1000, 16'h0000, 16'h0000, 8'd0,   1'b0, 16'h0000, 16'hE000, 8'd1,   1'b0);

        // Back-to-back stream with a one-cycle reset pulse in the middle.
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #2;
            rstn = (i == 20) ? 1'b0 : 1'b1;
            de   = 1'b1;
            vs   = (i < 2) || (i == 30);
            hs   = (i % 8 == 7);
            x    = 16'(i * 331 - 6000);
            y    = 16'(5000 - i * 257);
            cx   = 16'(i * 97 - 2048);
            cy   = 16'(i * 61);
            cnt  = 8'(i * 13 + 200);
            done = (i % 5 == 3);
        end
        @(posedge clk);
        #2;
        de = 1'b0; vs = 1'b0; hs = 1'b0; done = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
